// File: rtl/sn74hc165_reader.sv
// ---------------------------------------------------------------------------
// sn74hc165_reader
//
// Reads a chain of SN74HC165 PISO shift registers into the fabric. One scan
// has four parts. The parallel inputs are loaded with SH/LD_n low. The chain
// is then left to settle. Next the bits are clocked out on o_sck. Last, the
// captured word is presented with a one-cycle valid pulse.
//
// Every phase lasts CLK_DIV system cycles. A scan takes 2*CLK_DIV*WIDTH busy
// cycles, followed by one DONE cycle that carries o_valid.
//
// Parameters
//   WIDTH       : bits per scan (8 x number of chained devices), 8..64
//   CLK_DIV     : phase length / shift-clock half period in clk cycles, >= 3
//   AUTO_PERIOD : 0 = scan on i_start only; N > 0 = internal request every N
//
// Ports
//   clk, rst_n : system clock, async active-low reset
//   i_start    : one-cycle scan request (accepted in IDLE or DONE)
//   i_qh       : serial data from QH of the device nearest the FPGA (async)
//   o_ld_n     : SH/LD_n to all devices, 0 = parallel load
//   o_sck      : shift clock to all devices (devices shift on its rising edge)
//   o_data     : last completed scan, MSB = first bit shifted out
//   o_valid    : one-cycle pulse when o_data updates
//   o_busy     : high while a scan is in progress
// ---------------------------------------------------------------------------
module sn74hc165_reader #(
  parameter int WIDTH       = 8,
  parameter int CLK_DIV     = 6000,
  parameter int AUTO_PERIOD = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_qh,
  output logic             o_ld_n,
  output logic             o_sck,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_busy
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_HIGH,
    S_LOW,
    S_DONE
  } state_t;

  state_t           state;
  logic [PW-1:0]    phase;
  logic [BW-1:0]    bitcnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_nxt;
  logic [1:0]       qh_sync;
  logic             qh;
  logic             auto_tick;
  logic             start_req;
  logic             phase_last;

  // QH is driven by an off-chip device clocked by o_sck, so it is asynchronous
  // to clk. The phase length of at least 3 cycles leaves the two-flop
  // synchroniser time to settle before each sample is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) qh_sync <= '0;
    else        qh_sync <= {qh_sync[0], i_qh};
  end

  assign qh = qh_sync[1];

  // Free-running auto-scan counter. The tick is registered, so it becomes
  // visible in the cycle after the counter wraps to 0. If the FSM is busy
  // when the tick arrives, the tick is lost.
  generate
    if (AUTO_PERIOD > 0) begin : g_auto
      localparam int AW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
      logic [AW-1:0] auto_cnt;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          auto_cnt  <= '0;
          auto_tick <= 1'b0;
        end else begin
          auto_tick <= (auto_cnt == AW'(AUTO_PERIOD - 1));
          auto_cnt  <= (auto_cnt == AW'(AUTO_PERIOD - 1)) ? '0 : auto_cnt + AW'(1);
        end
      end
    end else begin : g_no_auto
      assign auto_tick = 1'b0;
    end
  endgenerate

  // Shift the synchronised QH into bit 0. Earlier bits move up toward the MSB,
  // so the first bit out of the chain ends up as the MSB.
  generate
    if (WIDTH == 1) begin : g_sh1
      assign shreg_nxt = qh;
    end else begin : g_shn
      assign shreg_nxt = {shreg[WIDTH-2:0], qh};
    end
  endgenerate

  assign start_req  = i_start | auto_tick;
  assign phase_last = (phase == PW'(CLK_DIV - 1));

  // The outputs are registered and are set on the transition into each state,
  // so pin levels change exactly when the state changes. o_sck rises on entry
  // to HIGH, which is when the devices shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      phase   <= '0;
      bitcnt  <= '0;
      shreg   <= '0;
      o_ld_n  <= 1'b1;
      o_sck   <= 1'b0;
      o_data  <= '0;
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        // DONE accepts a request exactly as IDLE does, so back-to-back scans
        // have no dead cycle.
        S_IDLE, S_DONE: begin
          phase  <= '0;
          bitcnt <= '0;
          o_sck  <= 1'b0;
          if (start_req) begin
            state  <= S_LOAD;
            o_ld_n <= 1'b0;
            o_busy <= 1'b1;
          end else begin
            state  <= S_IDLE;
            o_ld_n <= 1'b1;
            o_busy <= 1'b0;
          end
        end

        S_LOAD: begin
          if (phase_last) begin
            phase  <= '0;
            state  <= S_SETTLE;
            o_ld_n <= 1'b1;
          end else begin
            phase <= phase + 1'b1;
          end
        end

        // After the load, QH already shows the first bit. It is captured
        // before any shift clock is sent.
        S_SETTLE: begin
          if (phase_last) begin
            phase  <= '0;
            shreg  <= shreg_nxt;
            bitcnt <= BW'(1);
            if (WIDTH == 1) begin
              state   <= S_DONE;
              o_data  <= shreg_nxt;
              o_valid <= 1'b1;
              o_busy  <= 1'b0;
            end else begin
              state <= S_HIGH;
              o_sck <= 1'b1;
            end
          end else begin
            phase <= phase + 1'b1;
          end
        end

        S_HIGH: begin
          if (phase_last) begin
            phase <= '0;
            state <= S_LOW;
            o_sck <= 1'b0;
          end else begin
            phase <= phase + 1'b1;
          end
        end

        // The sample is taken at the end of LOW, a full sck period after the
        // rising edge, so the new QH has had time to pass the synchroniser.
        // The last bit goes straight into o_data on the same edge.
        S_LOW: begin
          if (phase_last) begin
            phase  <= '0;
            shreg  <= shreg_nxt;
            bitcnt <= bitcnt + 1'b1;
            if (bitcnt == BW'(WIDTH - 1)) begin
              state   <= S_DONE;
              o_data  <= shreg_nxt;
              o_valid <= 1'b1;
              o_busy  <= 1'b0;
            end else begin
              state <= S_HIGH;
              o_sck <= 1'b1;
            end
          end else begin
            phase <= phase + 1'b1;
          end
        end

        default: begin
          state  <= S_IDLE;
          phase  <= '0;
          o_ld_n <= 1'b1;
          o_sck  <= 1'b0;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sn74hc165_reader.sv
// ---------------------------------------------------------------------------
// Bench for sn74hc165_reader.
//
// It uses three DUT instances:
//   u8  : 8 bits, phase length 4, manual start
//   u16 : 16 bits, phase length 3, manual start (two devices)
//   ua  : 8 bits, phase length 4, auto-scan every 100 cycles
//
// Each instance drives a model of a 74HC165 chain. The chain loads its
// parallel inputs while ld_n is low and shifts on the rising edge of sck.
// QH is the MSB of the chain.
//
// The scan model works from request times, not from FSM state. A request at
// cycle c gives these windows:
//   busy  : c+1 .. c+2HW
//   ld_n  : low during the first H busy cycles
//   sck   : high during busy phases 2, 4, 6, ...
//   valid : at c+2HW+1, carrying the inputs held at the request
//
// Cycle index e counts clk rising edges. The outputs seen at a falling edge
// belong to the edge just before it. A request made in the cycle after edge e
// is taken at edge e+1.
// ---------------------------------------------------------------------------
module tb_sn74hc165_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int e = 0;
  always @(posedge clk) e <= e + 1;

  logic rst8_n = 1'b0, rst16_n = 1'b0, rsta_n = 1'b0;
  logic st8 = 1'b0, st16 = 1'b0, sta = 1'b0;
  logic [7:0]  pins8 = 8'hA5, pinsa = 8'h00;
  logic [15:0] pins16 = {8'h12, 8'h34};  // {near device, far device}

  logic qh8, qh16, qha;
  logic ld8_n, sck8, val8, busy8;
  logic ld16_n, sck16, val16, busy16;
  logic lda_n, scka, vala, busya;
  logic [7:0]  data8, dataa;
  logic [15:0] data16;

  sn74hc165_reader #(.WIDTH(8), .CLK_DIV(4), .AUTO_PERIOD(0)) u8 (
    .clk(clk), .rst_n(rst8_n), .i_start(st8), .i_qh(qh8), .o_ld_n(ld8_n),
    .o_sck(sck8), .o_data(data8), .o_valid(val8), .o_busy(busy8));

  sn74hc165_reader #(.WIDTH(16), .CLK_DIV(3), .AUTO_PERIOD(0)) u16 (
    .clk(clk), .rst_n(rst16_n), .i_start(st16), .i_qh(qh16), .o_ld_n(ld16_n),
    .o_sck(sck16), .o_data(data16), .o_valid(val16), .o_busy(busy16));

  sn74hc165_reader #(.WIDTH(8), .CLK_DIV(4), .AUTO_PERIOD(100)) ua (
    .clk(clk), .rst_n(rsta_n), .i_start(sta), .i_qh(qha), .o_ld_n(lda_n),
    .o_sck(scka), .o_data(dataa), .o_valid(vala), .o_busy(busya));

  // 74HC165 chain models. Serial input of the far device is tied low.
  logic [7:0]  ch8 = '0, cha = '0;
  logic [15:0] ch16 = '0;
  always @(posedge sck8 or negedge ld8_n)
    if (!ld8_n) ch8 <= pins8; else ch8 <= {ch8[6:0], 1'b0};
  always @(posedge sck16 or negedge ld16_n)
    if (!ld16_n) ch16 <= pins16; else ch16 <= {ch16[14:0], 1'b0};
  always @(posedge scka or negedge lda_n)
    if (!lda_n) cha <= pinsa; else cha <= {cha[6:0], 1'b0};
  assign qh8  = ch8[7];
  assign qh16 = ch16[15];
  assign qha  = cha[7];

  int nvec = 0, nerr = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at edge %0d: got %0h, want %0h", nm, e, act, exp);
    end
  endtask

  // Scan model state, one slot per instance
  string       nm[3]  = '{"u8", "u16", "ua"};
  int          m_h[3] = '{4, 3, 4};
  int          m_w[3] = '{8, 16, 8};
  bit          m_act[3];
  int          m_req[3], m_vat[3];
  logic [63:0] m_data[3], m_pend[3];

  task automatic step(input int i, input logic rn, input logic req, input logic [63:0] pins,
                      input logic ld_n, input logic sck, input logic val, input logic bsy,
                      input logic [63:0] dat);
    bit in_scan;
    int p;
    if (!rn) begin
      m_act[i]  = 0;
      m_data[i] = '0;
    end else if (m_act[i] && e == m_vat[i]) begin
      m_data[i] = m_pend[i];
    end
    in_scan = (rn === 1'b1) && m_act[i] && e > m_req[i] && e < m_vat[i];
    p = in_scan ? (e - m_req[i] - 1) / m_h[i] : -1;
    chk({nm[i], ".ld_n"},  64'(ld_n), 64'(!(in_scan && p == 0)));
    chk({nm[i], ".sck"},   64'(sck),  64'(in_scan && p >= 2 && (p % 2) == 0));
    chk({nm[i], ".busy"},  64'(bsy),  64'(in_scan));
    chk({nm[i], ".valid"}, 64'(val),  64'((rn === 1'b1) && m_act[i] && e == m_vat[i]));
    chk({nm[i], ".data"},  dat,       m_data[i]);
    if (m_act[i] && e >= m_vat[i]) m_act[i] = 0;
    if (rn && req && !m_act[i]) begin
      m_act[i]  = 1;
      m_req[i]  = e;
      m_vat[i]  = e + 2 * m_h[i] * m_w[i] + 1;
      m_pend[i] = pins;
    end
  endtask

  // Event tallies written only by the compare process
  int v8n = 0, v8_last = 0, ld8n = 0, busy8n = 0, sck8r = 0;
  int v16n = 0, v16_last = 0, sck16r = 0;
  int na = 0, ra = 0;
  int va_e[3];
  logic [7:0] va_d[3];

  initial begin
    bit tick;
    logic s8p = 1'b0, s16p = 1'b0;
    forever begin
      @(negedge clk);
      if (!rsta_n) ra = e + 1;
      tick = rsta_n && (e > ra) && (((e - ra) % 100) == 0);
      step(0, rst8_n,  st8,  64'(pins8),  ld8_n,  sck8,  val8,  busy8,  64'(data8));
      step(1, rst16_n, st16, 64'(pins16), ld16_n, sck16, val16, busy16, 64'(data16));
      step(2, rsta_n,  tick, 64'(pinsa),  lda_n,  scka,  vala,  busya,  64'(dataa));
      if (val8) begin v8n++; v8_last = e; end
      if (!ld8_n) ld8n++;
      if (busy8) busy8n++;
      if (sck8 && !s8p) sck8r++;
      s8p = sck8;
      if (val16) begin v16n++; v16_last = e; end
      if (sck16 && !s16p) sck16r++;
      s16p = sck16;
      if (vala) begin
        if (na < 3) begin va_e[na] = e; va_d[na] = dataa; end
        na++;
      end
    end
  end

  // Move to 2 time units after rising edge t
  task automatic at_edge(input int t);
    while (e < t) begin
      @(posedge clk);
      #2;
    end
  endtask

  int rel_e = 0;

  // Auto-scan input changes between scans: 0x00 -> 0xFF -> 0x5A
  initial begin
    wait (rel_e > 0);
    at_edge(rel_e + 170); pinsa = 8'hFF;
    at_edge(rel_e + 270); pinsa = 8'h5A;
  end

  initial begin
    int t0, s_v, s_ld, s_b, s_s, s_s16;
    at_edge(3);
    rel_e   = e;
    rst8_n  = 1'b1;
    rst16_n = 1'b1;
    rsta_n  = 1'b1;

    // Single scans: u8 reads 0xA5, u16 reads 0x1234
    t0 = 10;
    at_edge(t0);
    s_v = v8n; s_ld = ld8n; s_b = busy8n; s_s = sck8r; s_s16 = sck16r;
    st8 = 1'b1; st16 = 1'b1;
    at_edge(t0 + 1);
    st8 = 1'b0; st16 = 1'b0;
    at_edge(t0 + 98);
    chk("u8_valid_count", 64'(v8n - s_v), 64'd1);
    chk("u8_valid_latency", 64'(v8_last - t0), 64'd65);
    chk("u8_data_a5", 64'(data8), 64'hA5);
    chk("u8_ld_low_cycles", 64'(ld8n - s_ld), 64'd4);
    chk("u8_busy_cycles", 64'(busy8n - s_b), 64'd64);
    chk("u8_sck_rises", 64'(sck8r - s_s), 64'd7);
    chk("u16_valid_latency", 64'(v16_last - t0), 64'd97);
    chk("u16_data_1234", 64'(data16), 64'h1234);
    chk("u16_sck_rises", 64'(sck16r - s_s16), 64'd15);
    chk("u16_valid_count", 64'(v16n), 64'd1);

    // Starts while busy are dropped. A start in DONE begins LOAD at once.
    t0 = 120;
    at_edge(t0);
    s_v = v8n;
    st8 = 1'b1;
    at_edge(t0 + 1);  st8 = 1'b0;
    at_edge(t0 + 10); st8 = 1'b1;
    at_edge(t0 + 11); st8 = 1'b0;
    at_edge(t0 + 20); pins8 = 8'h3C;
    at_edge(t0 + 40); st8 = 1'b1;
    at_edge(t0 + 41); st8 = 1'b0;
    at_edge(t0 + 65);
    chk("u8_done_valid", 64'(val8), 64'd1);
    chk("u8_done_data", 64'(data8), 64'hA5);
    chk("u8_one_valid", 64'(v8n - s_v), 64'd0);
    st8 = 1'b1;
    at_edge(t0 + 66);
    st8 = 1'b0;
    chk("u8_reload_ld_n", 64'(ld8_n), 64'd0);
    chk("u8_reload_busy", 64'(busy8), 64'd1);
    at_edge(t0 + 131);
    chk("u8_b2b_valid_count", 64'(v8n - s_v), 64'd2);
    chk("u8_b2b_latency", 64'(v8_last - t0), 64'd130);
    chk("u8_data_3c", 64'(data8), 64'h3C);

    // Reset mid-scan aborts immediately, with no valid pulse
    t0 = 260;
    pins8 = 8'h96;
    at_edge(t0);
    s_v = v8n;
    st8 = 1'b1;
    at_edge(t0 + 1);  st8 = 1'b0;
    at_edge(t0 + 30); rst8_n = 1'b0;
    #1;
    chk("u8_rst_ld_n", 64'(ld8_n), 64'd1);
    chk("u8_rst_sck", 64'(sck8), 64'd0);
    chk("u8_rst_data", 64'(data8), 64'd0);
    chk("u8_rst_busy", 64'(busy8), 64'd0);
    at_edge(t0 + 33); rst8_n = 1'b1;
    at_edge(t0 + 70);
    chk("u8_abort_no_valid", 64'(v8n - s_v), 64'd0);
    at_edge(t0 + 72); st8 = 1'b1;
    at_edge(t0 + 73); st8 = 1'b0;
    at_edge(t0 + 72 + 66);
    chk("u8_post_rst_latency", 64'(v8_last - (t0 + 72)), 64'd65);
    chk("u8_data_96", 64'(data8), 64'h96);

    // Auto-scan results, with the release cycle counted as cycle 1
    at_edge(410);
    chk("ua_valid_count", 64'(na), 64'd3);
    chk("ua_valid0_cycle", 64'(va_e[0] - rel_e + 1), 64'd166);
    chk("ua_valid1_cycle", 64'(va_e[1] - rel_e + 1), 64'd266);
    chk("ua_valid2_cycle", 64'(va_e[2] - rel_e + 1), 64'd366);
    chk("ua_data0", 64'(va_d[0]), 64'h00);
    chk("ua_data1", 64'(va_d[1]), 64'hFF);
    chk("ua_data2", 64'(va_d[2]), 64'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
